// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: operation encodings, default latencies, FSM encoding, result payload.
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 3;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0] MDU_MULT  = 3'd0;
  localparam logic [OPW-1:0] MDU_MULTU = 3'd1;
  localparam logic [OPW-1:0] MDU_DIV   = 3'd2;
  localparam logic [OPW-1:0] MDU_DIVU  = 3'd3;
  localparam logic [OPW-1:0] MDU_MTHI  = 3'd4;
  localparam logic [OPW-1:0] MDU_MTLO  = 3'd5;
  localparam logic [OPW-1:0] MDU_NOP   = 3'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
  import mdu_pkg::*;

  logic            Start;
  logic [OPW-1:0]  MDUOp;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Busy;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (output Start, MDUOp, SrcA, SrcB, input  Busy, HI, LO);
  modport slave  (input  Start, MDUOp, SrcA, SrcB, output Busy, HI, LO);

endinterface

// File: rtl/mul_div_unit_div_core.sv
// Combinational 32-bit divider: magnitude divide with sign fix-up, overflow and zero-divisor detection.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] quot_c,
  output logic [XLEN-1:0] rem_c,
  output logic            div_zero_c
);

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg      = signed_i & dividend_i[XLEN-1];
    b_neg      = signed_i & divisor_i[XLEN-1];
    a_mag      = a_neg ? (~dividend_i + XLEN'(1)) : dividend_i;
    b_mag      = b_neg ? (~divisor_i + XLEN'(1)) : divisor_i;
    div_zero_c = (divisor_i == '0);
    q_mag      = div_zero_c ? '0 : (a_mag / b_mag);
    r_mag      = div_zero_c ? '0 : (a_mag % b_mag);
    quot_c     = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
    rem_c      = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
    // Most-negative / -1 cannot be represented; pin the architecturally defined result.
    if (signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF)) begin
      quot_c = 32'h8000_0000;
      rem_c  = '0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit: result computed at Start, committed to HI/LO after a fixed latency.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)
(
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  logic [0:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  hilo_t           pend_q, pend_d;
  logic            pend_wr_q, pend_wr_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d;

  logic [2*XLEN-1:0] mul_a, mul_b, prod_c;
  logic              mul_signed;
  logic [XLEN-1:0]   quot_c, rem_c;
  logic              div_zero_c, div_signed;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign mul_signed = (bus.MDUOp == MDU_MULT);
  assign mul_a      = mul_signed ? {{XLEN{bus.SrcA[XLEN-1]}}, bus.SrcA} : {{XLEN{1'b0}}, bus.SrcA};
  assign mul_b      = mul_signed ? {{XLEN{bus.SrcB[XLEN-1]}}, bus.SrcB} : {{XLEN{1'b0}}, bus.SrcB};
  assign prod_c     = mul_a * mul_b;
  assign div_signed = (bus.MDUOp == MDU_DIV);

  mdu_div_core u_div (
    .dividend_i (bus.SrcA),
    .divisor_i  (bus.SrcB),
    .signed_i   (div_signed),
    .quot_c     (quot_c),
    .rem_c      (rem_c),
    .div_zero_c (div_zero_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          case (bus.MDUOp)
            MDU_MULT, MDU_MULTU: begin
              pend_d    = prod_c;
              pend_wr_d = 1'b1;
              cnt_d     = CNTW'(MULT_CYCLES);
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_d    = '{hi: rem_c, lo: quot_c};
              pend_wr_d = ~div_zero_c;
              cnt_d     = CNTW'(DIV_CYCLES);
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            MDU_MTHI: hi_d = bus.SrcA;
            MDU_MTLO: lo_d = bus.SrcA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed MIPS cases plus randomized ops against an arithmetic model.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  mul_div_unit_if bus();

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_wr;
  int          m_left;

  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    calc = '0;
    case (op)
      3'd0: begin sa = $signed(a); sb = $signed(b); calc = sa * sb; end
      3'd1: begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); calc = sa * sb; end
      3'd2: begin
        if (b == 32'h0) calc = '0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) calc = {32'h0, 32'h8000_0000};
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); calc = {r, q}; end
      end
      3'd3: if (b != 32'h0) calc = {a % b, a / b};
      default: calc = '0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_res <= '0; m_wr <= 1'b0; m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_wr) begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
    end else if (bus.Start) begin
      if (bus.MDUOp <= 3'd3) begin
        m_left <= (bus.MDUOp <= 3'd1) ? 5 : 10;
        m_res  <= calc(bus.MDUOp, bus.SrcA, bus.SrcB);
        m_wr   <= !(bus.MDUOp >= 3'd2 && bus.SrcB == 32'h0);
      end else if (bus.MDUOp == 3'd4) m_hi <= bus.SrcA;
      else if (bus.MDUOp == 3'd5) m_lo <= bus.SrcA;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", {31'b0, bus.Busy}, {31'b0, m_left != 0});
      chk("model_hi", bus.HI, m_hi);
      chk("model_lo", bus.LO, m_lo);
    end
  end

  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd6; bus.SrcA = $urandom; bus.SrcB = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 40) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=%0d required<40", cyc);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [2:0] op;
    bus.Start = 1'b0; bus.MDUOp = 3'd6; bus.SrcA = '0; bus.SrcB = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, bus.Busy}, 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    pulse(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc);
    chk("mult_busy_len", cyc, 32'd5);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

    pulse(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hold_hi", bus.HI, 32'hFFFF_FFFF);
    chk("multu_hold_lo", bus.LO, 32'hFFFF_FFFA);
    wait_done(cyc);
    chk("multu_busy_len", cyc, 32'd5);
    chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
    chk("multu_lo", bus.LO, 32'h0000_0001);

    pulse(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("div_busy_len", cyc, 32'd10);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);

    pulse(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("divu_lo", bus.LO, 32'h7FFF_FFFC);
    chk("divu_hi", bus.HI, 32'h0000_0001);

    pulse(3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", bus.HI, 32'h1234);
    chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    pulse(3'd5, 32'h5678, 32'd0);
    chk("mtlo_lo", bus.LO, 32'h5678);
    chk("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
    pulse(3'd2, 32'd77, 32'd0);
    wait_done(cyc);
    chk("div0_busy_len", cyc, 32'd10);
    chk("div0_hi", bus.HI, 32'h1234);
    chk("div0_lo", bus.LO, 32'h5678);

    pulse(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    chk("ovf_hi", bus.HI, 32'h0);

    pulse(3'd3, 32'd100, 32'd7);
    bus.Start = 1'b1; bus.MDUOp = 3'd1; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd6;
    wait_done(cyc);
    chk("ign_busy_len", cyc + 1, 32'd10);
    chk("ign_lo", bus.LO, 32'd14);
    chk("ign_hi", bus.HI, 32'd2);

    pulse(3'd0, 32'd5, 32'd7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_commit_hi", bus.HI, 32'd0);
    chk("rst_no_commit_lo", bus.LO, 32'd0);

    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      pulse(op, pick(), pick());
      if (op <= 3'd3 && $urandom_range(0, 3) == 0) begin
        bus.Start = 1'b1; bus.MDUOp = 3'($urandom_range(0, 7)); bus.SrcA = pick(); bus.SrcB = pick();
        @(negedge clk);
        bus.Start = 1'b0; bus.MDUOp = 3'd6;
      end
      wait_done(cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
